cfg_sequencer: RTL

- Upstream feeder of the I2C byte master in the Si5340 config loader.
- Walks the configuration ROM from word 0 to WORD_NUMBER-1 and splits each 24-bit word into 3 bytes, MSB first.
- Presents the bytes to the I2C master as one write transaction per word.
- Inserts the mandatory post-preamble pause and reports done or error status.

---
 rtl/cfg_pkg.sv | 24 ++
 rtl/cfg_sequencer_if.sv | 14 +
 rtl/cfg_pause_timer.sv | 27 ++
 rtl/cfg_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared constants and FSM state type for the Si5340 configuration loader.
package cfg_pkg;

  localparam int MEM_WIDTH   = 24;
  localparam int DATA_WIDTH  = 8;
  localparam int WORD_NUMBER = 326;
  localparam logic [6:0] SLAVE_ADDR = 7'h74;
  localparam int CLK_FREQ    = 125_000_000;

  // 300 ms settle time after the preamble, in whole clock cycles
  localparam int PAUSE_CYCLES = CLK_FREQ / 1000 * 300;
  localparam int PAUSE_WORD   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_PAUSE,
    S_DONE,
    S_ERROR
  } seq_state_t;

endpackage

// File: rtl/cfg_sequencer_if.sv
// Byte channel between the configuration sequencer and the I2C byte master.
interface cfg_sequencer_if #(
  parameter int DATA_WIDTH = cfg_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  start;
  logic                  last;
  logic                  err;

  modport master (output data, valid, start, last, input ready, err);
  modport slave  (input data, valid, start, last, output ready, err);
endinterface

// File: rtl/cfg_pause_timer.sv
// Loadable down-counter; expired is high on the enabled cycle where the count is zero.
module cfg_pause_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/cfg_sequencer.sv
// Walks the configuration ROM and hands each word to the I2C master as one
// MSB-first write transaction, with a settle pause after the preamble words.
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | ROM address presented, waiting out the read latency
// LOAD    | ROM word captured into the byte shift register
// SEND    | bytes offered to the I2C master, one per handshake
// PAUSE   | settle delay after the preamble
// DONE    | every word sent; restartable
// ERROR   | aborted on a master error; rom_addr holds the failing word
module cfg_sequencer #(
  parameter int MEM_WIDTH    = cfg_pkg::MEM_WIDTH,
  parameter int DATA_WIDTH   = cfg_pkg::DATA_WIDTH,
  parameter int WORD_NUMBER  = cfg_pkg::WORD_NUMBER,
  parameter int PAUSE_WORD   = cfg_pkg::PAUSE_WORD,
  parameter int PAUSE_CYCLES = cfg_pkg::PAUSE_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [$clog2(WORD_NUMBER)-1:0] rom_addr,
  input  logic [MEM_WIDTH-1:0]           rom_data,
  cfg_sequencer_if.master                bus,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  import cfg_pkg::*;

  localparam int AW    = $clog2(WORD_NUMBER);
  localparam int PW    = $clog2(PAUSE_CYCLES + 1);
  localparam int BYTES = MEM_WIDTH / DATA_WIDTH;
  localparam int BW    = $clog2(BYTES);
  localparam logic [AW-1:0] LAST_WORD  = AW'(WORD_NUMBER - 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(BYTES - 1);
  localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_CYCLES - 1);

  seq_state_t state, state_nxt;

  logic [MEM_WIDTH-1:0] shift;
  logic [BW-1:0]        byte_cnt;
  logic [AW-1:0]        word_cnt;
  logic                 in_flight;
  logic                 last_hs;
  logic                 pause_here;
  logic                 pause_load;
  logic                 pause_en;
  logic                 pause_done;
  logic                 restart;
  logic                 word_adv;
  logic                 byte_adv;
  logic                 word_load;

  assign in_flight  = (state == S_FETCH) || (state == S_LOAD) ||
                      (state == S_SEND)  || (state == S_PAUSE);
  assign last_hs    = (state == S_SEND) && bus.ready && (byte_cnt == LAST_BYTE);
  // PAUSE_WORD of zero never matches, which disables the pause entirely
  assign pause_here = (int'(word_cnt) + 1) == PAUSE_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_FETCH;
      S_FETCH:                 state_nxt = S_LOAD;
      S_LOAD:                  state_nxt = S_SEND;
      S_SEND: begin
        if (last_hs) begin
          if (word_cnt == LAST_WORD) state_nxt = S_DONE;
          else if (pause_here)       state_nxt = S_PAUSE;
          else                       state_nxt = S_FETCH;
        end
      end
      S_PAUSE:                 if (pause_done) state_nxt = S_FETCH;
      default:                 state_nxt = S_IDLE;
    endcase
    // a master error overrides whatever the load was about to do
    if (in_flight && bus.err) state_nxt = S_ERROR;
  end

  always_comb begin
    bus.valid = (state == S_SEND);
    bus.data  = shift[MEM_WIDTH-1 -: DATA_WIDTH];
    bus.start = (state == S_SEND) && (byte_cnt == '0);
    bus.last  = (state == S_SEND) && (byte_cnt == LAST_BYTE);
    busy      = in_flight;
    done      = (state == S_DONE);
    err       = (state == S_ERROR);
  end

  assign restart    = !in_flight && (state_nxt == S_FETCH);
  assign word_adv   = ((state == S_SEND) || (state == S_PAUSE)) && (state_nxt == S_FETCH);
  assign word_load  = (state == S_LOAD) && (state_nxt == S_SEND);
  assign byte_adv   = (state == S_SEND) && (state_nxt == S_SEND) && bus.ready &&
                      (byte_cnt != LAST_BYTE);
  assign pause_load = (state == S_SEND) && (state_nxt == S_PAUSE);
  assign pause_en   = (state == S_PAUSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift    <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (restart) begin
        word_cnt <= '0;
      end else if (word_adv) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (word_load) begin
        shift    <= rom_data;
        byte_cnt <= '0;
      end else if (byte_adv) begin
        shift    <= shift << DATA_WIDTH;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  assign rom_addr = word_cnt;

  cfg_pause_timer #(
    .WIDTH (PW)
  ) u_pause (
    .clk        (clk),
    .rst        (rst),
    .load       (pause_load),
    .load_value (PAUSE_LOAD),
    .en         (pause_en),
    .expired    (pause_done)
  );

endmodule
